chart_playback_engine: RTL and testbench

CHART_PLAYBACK_ENGINE -- requirements
Module: chart_playback_engine

---
 rtl/chart_playback_engine_if.sv | 26 ++
 rtl/chart_playback_engine.sv | 124 ++++++++++++
 tb/tb_chart_playback_engine.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/chart_playback_engine_if.sv
// Handshake and data bundle between the chart playback engine and its surroundings.
// The engine takes the slave side; the player/storage/record-writer side takes the master side.
interface chart_playback_engine_if;
  logic        start;
  logic        abort;
  logic [15:0] note_cnt;
  logic [15:0] note_idx;
  logic [8:0]  note_in;
  logic [8:0]  keys;
  logic [8:0]  cur_note;
  logic        busy;
  logic [15:0] score;
  logic        rec_valid;
  logic        rec_ready;
  logic        done;

  modport master (
    output start, abort, note_cnt, note_in, keys, rec_ready,
    input  note_idx, cur_note, busy, score, rec_valid, done
  );

  modport slave (
    input  start, abort, note_cnt, note_in, keys, rec_ready,
    output note_idx, cur_note, busy, score, rec_valid, done
  );
endinterface

// File: rtl/chart_playback_engine.sv
// Steps through a stored chart at TICK_DIV clocks per step, scores exact key matches
// and hands the final score to a record writer over a valid/ready handshake.
module chart_playback_engine #(
  parameter int TICK_DIV = 25_000_000,
  parameter int HIT_PTS  = 10
) (
  input  logic                   clk,
  input  logic                   sys_rst,
  chart_playback_engine_if.slave bus
);

  localparam int               DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(1);
  localparam logic [16:0]      HIT_ADD  = 17'(HIT_PTS);

  typedef enum logic [1:0] {IDLE, PLAY, REPORT} state_t;

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div;
  logic [15:0]      cnt;
  logic [15:0]      note_idx;
  logic [8:0]       cur_note;
  logic [15:0]      score;
  logic             rec_valid;
  logic             done;

  logic             step_end;
  logic             last_step;
  logic             hit;
  logic             start_ok;
  logic [16:0]      score_sum;

  assign step_end  = (state == PLAY) && (div == DIV_LAST);
  assign last_step = (note_idx == cnt - 16'd1);
  assign hit       = (cur_note != 9'd0) && (bus.keys == cur_note);
  assign score_sum = {1'b0, score} + HIT_ADD;
  assign start_ok  = (state == IDLE) && bus.start && !bus.abort;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_ok) state_next = (bus.note_cnt == 16'd0) ? REPORT : PLAY;
      end
      PLAY: begin
        if (bus.abort)                 state_next = IDLE;
        else if (step_end && last_step) state_next = REPORT;
      end
      REPORT: begin
        if (bus.abort || bus.rec_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The chart length is latched at start so the storage side may change it mid-game.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      div       <= '0;
      cnt       <= '0;
      note_idx  <= '0;
      cur_note  <= '0;
      score     <= '0;
      rec_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            div       <= '0;
            cnt       <= bus.note_cnt;
            note_idx  <= '0;
            cur_note  <= '0;
            score     <= '0;
            rec_valid <= (bus.note_cnt == 16'd0);
          end
        end
        PLAY: begin
          if (bus.abort) begin
            div      <= '0;
            cur_note <= '0;
          end else begin
            div <= step_end ? '0 : div + DIV_W'(1);
            if (div == DIV_LOAD) cur_note <= bus.note_in;
            if (step_end) begin
              if (hit) score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
              if (last_step) begin
                cur_note  <= '0;
                rec_valid <= 1'b1;
              end else begin
                note_idx <= note_idx + 16'd1;
              end
            end
          end
        end
        REPORT: begin
          if (bus.abort) begin
            rec_valid <= 1'b0;
          end else if (bus.rec_ready) begin
            rec_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.note_idx  = note_idx;
  assign bus.cur_note  = cur_note;
  assign bus.busy      = (state != IDLE);
  assign bus.score     = score;
  assign bus.rec_valid = rec_valid;
  assign bus.done      = done;

endmodule

// File: tb/tb_chart_playback_engine.sv
// Randomized games against a step-level score model, plus directed abort, empty-chart,
// saturation and reset-in-REPORT scenarios.
module tb_chart_playback_engine;

  localparam int TICK_DIV  = 4;
  localparam int HIT_PTS   = 10;
  localparam int MAX_STEPS = 8192;

  localparam logic [8:0] C4 = 9'h001;
  localparam logic [8:0] D4 = 9'h002;
  localparam logic [8:0] G4 = 9'h010;

  logic clk = 1'b0;
  logic sys_rst;
  always #5 clk = ~clk;

  chart_playback_engine_if bus ();

  chart_playback_engine #(.TICK_DIV(TICK_DIV), .HIT_PTS(HIT_PTS)) dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (bus.slave)
  );

  logic [8:0] chart     [MAX_STEPS];
  logic [8:0] step_keys [MAX_STEPS];

  // Chart storage: registered read, one cycle behind note_idx.
  always @(posedge clk) bus.note_in <= chart[bus.note_idx[12:0]];

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int add_hit(input int s);
    return (s + HIT_PTS > 65535) ? 65535 : s + HIT_PTS;
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0:       chart[i] = 9'd0;
        1:       chart[i] = 9'(1 << $urandom_range(0, 8));
        default: chart[i] = 9'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0:       step_keys[i] = chart[i];
        1:       step_keys[i] = 9'($urandom);
        default: step_keys[i] = chart[i] | 9'(1 << $urandom_range(0, 8));
      endcase
    end
  endtask

  // Plays chart[0..n-1] with step_keys; mode 0 finishes via rec_ready, mode 1 resets mid-REPORT.
  task automatic apply_stimulus(input int n, input int hold_cycles, input bit fiddle, input int mode);
    int expected = 0;
    bus.note_cnt = 16'(n);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (fiddle) bus.note_cnt = 16'($urandom);
    for (int i = 0; i < n; i++) begin
      bus.keys = step_keys[i];
      @(negedge clk);
      @(negedge clk);
      check_output("play_cur_note", 32'(bus.cur_note), 32'(chart[i]));
      check_output("play_busy", 32'(bus.busy), 32'd1);
      check_output("play_rec_valid", 32'(bus.rec_valid), 32'd0);
      check_output("play_score", 32'(bus.score), 32'(expected));
      if (fiddle) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      if (chart[i] != 9'd0 && step_keys[i] == chart[i]) expected = add_hit(expected);
      @(negedge clk);
    end
    check_output("report_rec_valid", 32'(bus.rec_valid), 32'd1);
    check_output("report_busy", 32'(bus.busy), 32'd1);
    check_output("report_cur_note", 32'(bus.cur_note), 32'd0);
    check_output("report_score", 32'(bus.score), 32'(expected));
    check_output("report_done", 32'(bus.done), 32'd0);
    for (int h = 0; h < hold_cycles; h++) begin
      @(negedge clk);
      check_output("wait_rec_valid", 32'(bus.rec_valid), 32'd1);
      check_output("wait_score", 32'(bus.score), 32'(expected));
      check_output("wait_done", 32'(bus.done), 32'd0);
    end
    if (mode == 1) begin
      #2 sys_rst = 1'b1;
      #1;
      check_output("arst_note_idx", 32'(bus.note_idx), 32'd0);
      check_output("arst_cur_note", 32'(bus.cur_note), 32'd0);
      check_output("arst_score", 32'(bus.score), 32'd0);
      check_output("arst_rec_valid", 32'(bus.rec_valid), 32'd0);
      check_output("arst_done", 32'(bus.done), 32'd0);
      check_output("arst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      sys_rst = 1'b0;
      @(negedge clk);
      check_output("post_rst_busy", 32'(bus.busy), 32'd0);
      check_output("post_rst_score", 32'(bus.score), 32'd0);
    end else begin
      bus.rec_ready = 1'b1;
      @(negedge clk);
      bus.rec_ready = 1'b0;
      check_output("ack_rec_valid", 32'(bus.rec_valid), 32'd0);
      check_output("ack_done", 32'(bus.done), 32'd1);
      check_output("ack_busy", 32'(bus.busy), 32'd0);
      check_output("ack_score", 32'(bus.score), 32'(expected));
      @(negedge clk);
      check_output("done_pulse_end", 32'(bus.done), 32'd0);
    end
  endtask

  // Abort lands in step1 at div==2, together with start and rec_ready to exercise priority.
  task automatic abort_in_play();
    int expected = 0;
    chart[0] = C4; chart[1] = D4; chart[2] = G4;
    bus.note_cnt = 16'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.keys = C4;
    repeat (4) @(negedge clk);
    expected = add_hit(expected);
    bus.keys = 9'd0;
    @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.rec_ready = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    bus.rec_ready = 1'b0;
    check_output("abort_busy", 32'(bus.busy), 32'd0);
    check_output("abort_cur_note", 32'(bus.cur_note), 32'd0);
    check_output("abort_rec_valid", 32'(bus.rec_valid), 32'd0);
    check_output("abort_score", 32'(bus.score), 32'(expected));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("abort_idle_done", 32'(bus.done), 32'd0);
      check_output("abort_idle_rec_valid", 32'(bus.rec_valid), 32'd0);
    end
  endtask

  task automatic abort_in_report();
    bus.note_cnt = 16'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_output("abort_rep_valid_before", 32'(bus.rec_valid), 32'd1);
    bus.abort = 1'b1;
    bus.rec_ready = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.rec_ready = 1'b0;
    check_output("abort_rep_rec_valid", 32'(bus.rec_valid), 32'd0);
    check_output("abort_rep_done", 32'(bus.done), 32'd0);
    check_output("abort_rep_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    sys_rst       = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.rec_ready = 1'b0;
    bus.keys      = 9'd0;
    bus.note_cnt  = 16'd0;
    for (int i = 0; i < MAX_STEPS; i++) begin
      chart[i] = 9'd0;
      step_keys[i] = 9'd0;
    end
    repeat (3) @(negedge clk);
    check_output("rst_note_idx", 32'(bus.note_idx), 32'd0);
    check_output("rst_cur_note", 32'(bus.cur_note), 32'd0);
    check_output("rst_score", 32'(bus.score), 32'd0);
    check_output("rst_rec_valid", 32'(bus.rec_valid), 32'd0);
    check_output("rst_done", 32'(bus.done), 32'd0);
    check_output("rst_busy", 32'(bus.busy), 32'd0);
    sys_rst = 1'b0;
    @(negedge clk);
    check_output("first_edge_busy", 32'(bus.busy), 32'd0);
    check_output("first_edge_score", 32'(bus.score), 32'd0);

    chart[0] = C4; chart[1] = 9'd0; chart[2] = G4;
    step_keys[0] = C4; step_keys[1] = 9'd0; step_keys[2] = G4;
    apply_stimulus(3, 0, 1'b0, 0);

    step_keys[0] = C4 | D4; step_keys[1] = C4 | D4; step_keys[2] = C4 | D4;
    apply_stimulus(3, 0, 1'b0, 0);

    apply_stimulus(0, 5, 1'b0, 0);

    abort_in_play();
    abort_in_report();

    fill_random(4);
    apply_stimulus(4, 2, 1'b0, 1);
    apply_stimulus(4, 1, 1'b0, 0);

    for (int g = 0; g < 20; g++) begin
      int n;
      n = $urandom_range(0, 8);
      fill_random(n);
      apply_stimulus(n, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
    end

    for (int i = 0; i < 6560; i++) begin
      chart[i] = C4;
      step_keys[i] = C4;
    end
    apply_stimulus(6560, 1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
